// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Which requester owns the in-flight transaction
    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } owner_e;

    // Legal byte masks on the load/store port
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: on a tie the requester that did not win last time gets the grant.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       i_inst_valid,
    input  logic       i_data_valid,
    input  owner_e     i_last_grant,
    input  logic       i_en,
    output logic [1:0] o_grant,       // bit 0 = inst, bit 1 = data
    output owner_e     o_next_last
);

    logic w_pick_data;

    // Data wins when alone, or on a tie when inst had the previous grant
    assign w_pick_data = i_data_valid && (!i_inst_valid || (i_last_grant == OWN_INST));

    // Grant is only issued when the arbiter is open to a new request
    always_comb begin
        o_grant     = 2'b00;
        o_next_last = i_last_grant;
        if (i_en && (i_inst_valid || i_data_valid)) begin
            if (w_pick_data) begin
                o_grant     = 2'b10;
                o_next_last = OWN_DATA;
            end else begin
                o_grant     = 2'b01;
                o_next_last = OWN_INST;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and load/store ports,
// one transaction at a time, with round-robin arbitration per transaction.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pInst_bReqValid,
    output logic                  pInst_bReqReady,
    input  logic [ADDR_WIDTH-1:0] pInst_bReqAddr,
    output logic                  pInst_bRespValid,
    output logic [DATA_WIDTH-1:0] pInst_bRespData,
    input  logic                  pData_bReqValid,
    output logic                  pData_bReqReady,
    input  logic                  pData_bReqWen,
    input  logic [ADDR_WIDTH-1:0] pData_bReqAddr,
    input  logic [DATA_WIDTH-1:0] pData_bReqWdata,
    input  logic [3:0]            pData_bReqMask,
    output logic                  pData_bRespValid,
    output logic [DATA_WIDTH-1:0] pData_bRespData,
    output logic                  pMem_bEn,
    output logic                  pMem_bWen,
    output logic [ADDR_WIDTH-1:0] pMem_bAddr,
    output logic [DATA_WIDTH-1:0] pMem_bWdata,
    output logic [3:0]            pMem_bMask,
    input  logic [DATA_WIDTH-1:0] pMem_bRdata
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e                r_state;
    owner_e                r_last;
    owner_e                r_owner;
    logic                  r_wen;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_inst_rvalid;
    logic                  r_data_rvalid;
    logic [DATA_WIDTH-1:0] r_inst_rdata;
    logic [DATA_WIDTH-1:0] r_data_rdata;

    logic                  w_open;
    logic [1:0]            w_grant;
    owner_e                w_next_last;
    logic                  w_accept;
    logic                  w_last_wait;

    assign w_open      = (r_state == IDLE) || (r_state == RESP);
    assign w_accept    = |w_grant;
    assign w_last_wait = (r_state == WAIT) && (r_cnt == CNT_LAT);

    mem_arb_rr u_rr (
        .i_inst_valid (pInst_bReqValid),
        .i_data_valid (pData_bReqValid),
        .i_last_grant (r_last),
        .i_en         (w_open),
        .o_grant      (w_grant),
        .o_next_last  (w_next_last)
    );

    assign pInst_bReqReady  = w_grant[0];
    assign pData_bReqReady  = w_grant[1];
    assign pMem_bEn         = w_accept;
    assign pInst_bRespValid = r_inst_rvalid;
    assign pData_bRespValid = r_data_rvalid;
    assign pInst_bRespData  = r_inst_rdata;
    assign pData_bRespData  = r_data_rdata;

    // Memory request fields follow the winner; a fetch never writes
    always_comb begin
        if (w_grant[1]) begin
            pMem_bWen   = pData_bReqWen;
            pMem_bAddr  = pData_bReqAddr;
            pMem_bWdata = pData_bReqWdata;
            pMem_bMask  = pData_bReqMask;
        end else begin
            pMem_bWen   = 1'b0;
            pMem_bAddr  = pInst_bReqAddr;
            pMem_bWdata = '0;
            pMem_bMask  = MASK_W;
        end
    end

    // FSM, latency counter, ownership tracking and registered response outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last        <= OWN_INST;
            r_owner       <= OWN_INST;
            r_wen         <= 1'b0;
            r_cnt         <= '0;
            r_inst_rvalid <= 1'b0;
            r_data_rvalid <= 1'b0;
            r_inst_rdata  <= '0;
            r_data_rdata  <= '0;
        end else begin
            r_inst_rvalid <= 1'b0;
            r_data_rvalid <= 1'b0;
            r_last        <= w_next_last;
            unique case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        r_state <= WAIT;
                        r_owner <= w_grant[1] ? OWN_DATA : OWN_INST;
                        r_wen   <= pMem_bWen;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    if (w_last_wait) begin
                        r_state <= RESP;
                        if (r_owner == OWN_DATA) begin
                            r_data_rvalid <= 1'b1;
                            // Stores complete with zero data
                            r_data_rdata  <= r_wen ? '0 : pMem_bRdata;
                        end else begin
                            r_inst_rvalid <= 1'b1;
                            r_inst_rdata  <= pMem_bRdata;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a latency-delayed memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned LAT    = 3;
    localparam int unsigned BUDGET = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        data_valid = 1'b0;
    logic        data_wen = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_mask = MASK_W;

    logic        pInst_bReqReady, pInst_bRespValid;
    logic [31:0] pInst_bRespData;
    logic        pData_bReqReady, pData_bRespValid;
    logic [31:0] pData_bRespData;
    logic        pMem_bEn, pMem_bWen;
    logic [31:0] pMem_bAddr, pMem_bWdata, pMem_bRdata;
    logic [3:0]  pMem_bMask;

    mem_port_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_LATENCY (LAT)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .pInst_bReqValid  (inst_valid),
        .pInst_bReqReady  (pInst_bReqReady),
        .pInst_bReqAddr   (inst_addr),
        .pInst_bRespValid (pInst_bRespValid),
        .pInst_bRespData  (pInst_bRespData),
        .pData_bReqValid  (data_valid),
        .pData_bReqReady  (pData_bReqReady),
        .pData_bReqWen    (data_wen),
        .pData_bReqAddr   (data_addr),
        .pData_bReqWdata  (data_wdata),
        .pData_bReqMask   (data_mask),
        .pData_bRespValid (pData_bRespValid),
        .pData_bRespData  (pData_bRespData),
        .pMem_bEn         (pMem_bEn),
        .pMem_bWen        (pMem_bWen),
        .pMem_bAddr       (pMem_bAddr),
        .pMem_bWdata      (pMem_bWdata),
        .pMem_bMask       (pMem_bMask),
        .pMem_bRdata      (pMem_bRdata)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory contents as a fixed function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0013;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Memory: read data appears LAT cycles after the strobe; junk otherwise
    logic [31:0] pipe [LAT];
    initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
    always @(posedge clock) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= (pMem_bEn && !pMem_bWen) ? mem_word(pMem_bAddr) : 32'($urandom);
    end
    assign pMem_bRdata = pipe[LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no ready, expected one within %0d cycles", name, BUDGET);
    endtask

    // Reference model: memory busy for LAT+1 cycles after each accept; ties alternate
    typedef struct {
        int unsigned cyc;
        logic        is_data;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    owner_e      m_last    = OWN_INST;
    int unsigned m_free_at = 0;

    wire avail = (cyc >= m_free_at);
    wire win_d = avail && data_valid && (!inst_valid || (m_last == OWN_INST));
    wire win_i = avail && inst_valid && !win_d;
    wire win   = win_i || win_d;

    wire [71:0] exp_req = {win_i, win_d, win, win_d & data_wen,
                           win ? (win_d ? data_addr : inst_addr) : 32'h0,
                           win_d ? data_wdata : 32'h0, win_d ? data_mask : 4'h0};
    wire [71:0] act_req = {pInst_bReqReady, pData_bReqReady, pMem_bEn, win & pMem_bWen,
                           win ? pMem_bAddr : 32'h0,
                           win_d ? pMem_bWdata : 32'h0, win_d ? pMem_bMask : 4'h0};

    // Monitor: compare responses against the scoreboard and requests against the model
    always @(negedge clock) begin
        if (reset) begin
            check("reset_outputs",
                  {pInst_bRespValid, pData_bRespValid, pInst_bRespData, pData_bRespData}, '0);
            exp_q.delete();
            m_last    <= OWN_INST;
            m_free_at <= 0;
        end else begin
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                check("resp_valid", {pInst_bRespValid, pData_bRespValid},
                      {!exp_q[0].is_data, exp_q[0].is_data});
                check("resp_data", exp_q[0].is_data ? pData_bRespData : pInst_bRespData,
                      exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                check("resp_silent", {pInst_bRespValid, pData_bRespValid}, 2'b00);
            end
            check("request_side", act_req, exp_req);
            if (win) begin
                exp_q.push_back('{cyc: cyc + LAT + 1, is_data: win_d,
                                  data: (win_d && data_wen) ? 32'h0
                                        : mem_word(win_d ? data_addr : inst_addr)});
                m_last    <= win_d ? OWN_DATA : OWN_INST;
                m_free_at <= cyc + LAT + 1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic inst_req(input logic [31:0] addr);
        int unsigned waited = 0;
        inst_valid = 1'b1;
        inst_addr  = addr;
        @(negedge clock);
        while (!pInst_bReqReady && waited < BUDGET) begin
            waited++;
            @(negedge clock);
        end
        if (!pInst_bReqReady) fail_timeout("inst_handshake");
        @(posedge clock);
        #1;
        inst_valid = 1'b0;
    endtask

    task automatic data_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mask);
        int unsigned waited = 0;
        data_valid = 1'b1;
        data_wen   = wen;
        data_addr  = addr;
        data_wdata = wdata;
        data_mask  = mask;
        @(negedge clock);
        while (!pData_bReqReady && waited < BUDGET) begin
            waited++;
            @(negedge clock);
        end
        if (!pData_bReqReady) fail_timeout("data_handshake");
        @(posedge clock);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic inst_stream(input int n, input int max_gap);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clock);
                #1;
            end
            inst_req(32'($urandom) & 32'hFFFF_FFFC);
        end
    endtask

    task automatic data_stream(input int n, input int max_gap);
        logic [3:0] m;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clock);
                #1;
            end
            case ($urandom_range(0, 2))
                0:       m = MASK_B;
                1:       m = MASK_H;
                default: m = MASK_W;
            endcase
            data_req(1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFF_FFFC, 32'($urandom), m);
        end
    endtask

    initial begin
        idle(3);
        reset = 1'b0;

        // Tie straight out of reset: load first, fetch on its response cycle
        fork
            inst_req(32'h0000_0100);
            data_req(1'b0, 32'h0000_0200, 32'h0, MASK_W);
        join
        idle(LAT + 3);

        // Half-word store completes with zero data
        data_req(1'b1, 32'h0000_0204, 32'hDEAD_BEEF, MASK_H);
        idle(LAT + 3);

        // Lone fetch
        inst_req(32'h8000_0000);
        idle(LAT + 3);

        // Fetch held continuously: one accept per LAT+1 cycles
        inst_stream(4, 0);
        idle(LAT + 3);

        // Reset one cycle after a load accept aborts it
        data_req(1'b0, 32'h0000_0300, 32'h0, MASK_W);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(LAT + 4);

        // Tie after reset goes to data again
        fork
            inst_req(32'h0000_0400);
            data_req(1'b0, 32'h0000_0404, 32'h0, MASK_B);
        join
        idle(LAT + 3);

        // Both streaming back to back: strict alternation
        fork
            inst_stream(4, 0);
            data_stream(4, 0);
        join
        idle(LAT + 3);

        // Random traffic with gaps
        fork
            inst_stream(25, 3);
            data_stream(25, 3);
        join
        idle(LAT + 4);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency simulation memory between the core's instruction-fetch port and its load/store port. It arbitrates per transaction with two-way round-robin and presents one request at a time to memory. It waits the configured read latency, then returns the response to the winning requester. The block sits between the fetch/LSU stages and the memory model, replacing the dual-port memory arrangement for single-port configurations.

## Interface
- ADDR_WIDTH, 32, address width for all ports
- DATA_WIDTH, 32, data width for all ports
- MEM_LATENCY, 1, cycles from request acceptance to valid memory read data; legal range 1..15

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- pInst_bReqValid  in  1  fetch request pending
- pInst_bReqReady  out  1  fetch request accepted this cycle
- pInst_bReqAddr  in  ADDR_WIDTH  fetch address
- pInst_bRespValid  out  1  one-cycle pulse, fetch data valid
- pInst_bRespData  out  DATA_WIDTH  fetched word
- pData_bReqValid  in  1  load/store request pending
- pData_bReqReady  out  1  load/store accepted this cycle
- pData_bReqWen  in  1  1 = store, 0 = load
- pData_bReqAddr  in  ADDR_WIDTH  load/store address
- pData_bReqWdata  in  DATA_WIDTH  store data
- pData_bReqMask  in  4  byte mask; legal values 0001, 0011, 1111
- pData_bRespValid  out  1  one-cycle pulse, load data valid or store complete
- pData_bRespData  out  DATA_WIDTH  load data; 0 for stores
- pMem_bEn  out  1  memory request strobe
- pMem_bWen  out  1  write strobe
- pMem_bAddr  out  ADDR_WIDTH  memory address
- pMem_bWdata  out  DATA_WIDTH  write data
- pMem_bMask  out  4  write byte mask, forwarded unchanged
- pMem_bRdata  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after pMem_bEn

## Operation
- FSM states:
  - IDLE: accepts a request when one is pending.
  - WAIT: counts latency.
  - RESP: emits the response pulse and may accept the next request.
- Transitions:
  - IDLE/RESP to WAIT on accept.
  - RESP to IDLE when no request is accepted.
  - WAIT to RESP when the counter equals MEM_LATENCY.
- Accept condition: state is IDLE or RESP and at least one valid is set.
  - Only the winner's ready is driven high. The loser's ready is 0.
  - pMem_bEn = accept. The pMem_* fields are driven combinationally from the winner.
  - pMem_bWen is always 0 for a fetch.
- Round-robin: the lastGrant register resets to INST.
  - On a tie, the requester not in lastGrant wins.
  - A lone requester always wins.
  - lastGrant updates on every accept.
- On accept, register the owner (INST/DATA) and the write flag. Clear the latency counter to 1.
  - The counter width is $clog2(MEM_LATENCY+1). It saturates and never wraps.
- In the final WAIT cycle, capture pMem_bRdata into the response register. Capture 0 if the transaction is a store.
- RESP raises exactly one of pInst_bRespValid or pData_bRespValid for one cycle, per the owner.
  - Response data holds until the next capture.
  - There is no response back-pressure.
- Requester rule: valid and all request fields stay stable until ready. The arbiter never withdraws ready within a cycle.
- Illegal mask values are forwarded unchanged and are not checked.
- While in WAIT, both readies are 0 and pMem_bEn is 0.

## Timing
- Request accepted at cycle T. pMem_bEn is high in T and the memory samples at the end of T.
- pMem_bRdata is valid in cycle T+MEM_LATENCY. xRespValid is high in cycle T+MEM_LATENCY+1.
- Back-to-back accept is allowed in the RESP cycle. Peak throughput is one transaction per MEM_LATENCY+1 cycles.
- Reset values: state IDLE, lastGrant INST, counter 0, both RespValid 0, both RespData 0.
  - Combinational outputs (readies, pMem_*) follow from state IDLE and the inputs.
- Reset asserted mid-transaction aborts it immediately. No response pulse is issued, including after reset release. The memory result is discarded.
- Simultaneous requests on a fresh reset: data wins first, then inst.

## Structure
- Shared package mem_arb_pkg:
  - state enum {IDLE, WAIT, RESP}
  - owner enum {OWN_INST, OWN_DATA}
  - mask constants MASK_B=4'b0001, MASK_H=4'b0011, MASK_W=4'b1111
- Sub-module mem_arb_rr: a 2-way round-robin picker.
  - Inputs: two valids, lastGrant, accept enable.
  - Outputs: one-hot grant and next lastGrant.
- Top level holds the FSM, counter, owner/write registers, response register and port muxing.

## Test plan
- MEM_LATENCY=1, single fetch at 0x8000_0000, memory returns 0x0000_0013 -> pInst_bRespValid pulses 2 cycles after accept with data 0x0000_0013; data side stays silent.
- Both valids high from reset, inst 0x100 / load 0x200 -> load is accepted first, fetch on its RESP cycle; the two pulses are separated by MEM_LATENCY+1 cycles.
- Store 0xDEADBEEF, mask 0011, to 0x204 -> pMem_bWen=1, pMem_bMask=0011; pData_bRespValid pulses with data 0.
- MEM_LATENCY=3 with fetch held high continuously -> an accept every 4 cycles; ready is 0 for all WAIT cycles.
- Reset asserted one cycle after a load accept -> no pData_bRespValid afterwards; state IDLE; the next tie goes to data.
- Both requesters streaming for 8 transactions -> grants strictly alternate, starting with data, with no starvation.
